// File: rtl/simd_pkg.sv
// -----------------------------------------------------------------------------
// simd_pkg
//   Shared types for the SIMD processing-element sequencer:
//     - opcode_e     : instruction opcodes (4-bit opcode field)
//     - state_e      : sequencer FSM states
//     - inst_class_e : decoded instruction class
//     - field-extraction localparams for the 12-bit instruction word
//     - decode()     : maps an opcode to its instruction class
// -----------------------------------------------------------------------------
package simd_pkg;

  // Instruction word layout: [ address | opcode ]
  localparam int OPC_LSB   = 0;
  localparam int OPC_WIDTH = 4;
  localparam int ADDR_LSB  = OPC_LSB + OPC_WIDTH;

  typedef enum logic [OPC_WIDTH-1:0] {
    OP_NOP     = 4'h0,
    OP_ADD     = 4'h1,
    OP_SUB     = 4'h2,
    OP_MUL     = 4'h3,
    OP_STOP    = 4'h8,
    OP_FETCH_A = 4'h9,
    OP_FETCH_B = 4'hA
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_STOP,
    CLS_FETCH_A,
    CLS_FETCH_B,
    CLS_ILLEGAL
  } inst_class_e;

  // Any opcode outside the defined set decodes as CLS_ILLEGAL; the
  // sequencer decides whether that traps or behaves as a NOP.
  function automatic inst_class_e decode(input logic [OPC_WIDTH-1:0] opc);
    inst_class_e cls;
    case (opcode_e'(opc))
      OP_NOP:                 cls = CLS_NOP;
      OP_ADD, OP_SUB, OP_MUL: cls = CLS_ALU;
      OP_STOP:                cls = CLS_STOP;
      OP_FETCH_A:             cls = CLS_FETCH_A;
      OP_FETCH_B:             cls = CLS_FETCH_B;
      default:                cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/simd_seq_ctrl.sv
// -----------------------------------------------------------------------------
// simd_seq_ctrl
//   Program sequencer for the SIMD processing element. On a start pulse it
//   walks instruction memory from address 0, decodes each instruction and
//   drives the RAM A/B read strobes and the PE operation handshake until a
//   STOP instruction, then pulses done for one cycle.
//
//   Optional feature macro: SIMD_SEQ_ILLEGAL_TRAP_EN
//     defined   : an illegal opcode sets the sticky err flag and ends the run
//                 (done pulses, PC stays on the offending instruction)
//     undefined : illegal opcodes execute as NOP and err is tied low
//
//   Ports
//     clk              in   clock, rising edge
//     rstn             in   asynchronous active-low reset
//     start            in   one-cycle run request, honoured only in IDLE
//     busy             out  high in every state except IDLE
//     done             out  one-cycle pulse after STOP (or a trap)
//     err              out  sticky illegal-opcode flag, cleared by start
//     inst_read_addr   out  instruction address (= PC)
//     inst_read_data   in   instruction word, combinational read
//     ram_a_rd_en      out  RAM A read strobe
//     ram_a_read_addr  out  RAM A address, holds between strobes
//     ram_b_rd_en      out  RAM B read strobe
//     ram_b_read_addr  out  RAM B address, holds between strobes
//     pe_valid         out  PE operation request
//     pe_opcode        out  operation presented with pe_valid, else 0
//     pe_ready         in   PE accepts the operation
// -----------------------------------------------------------------------------
module simd_seq_ctrl
  import simd_pkg::*;
#(
  parameter  int OPCODE_LEN      = 4,
  parameter  int PC_WIDTH        = 12,
  parameter  int INST_LEN        = 12,
  parameter  int DRAM_DEPTH      = 256,
  localparam int DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [PC_WIDTH-1:0]        inst_read_addr,
  input  logic [INST_LEN-1:0]        inst_read_data,
  output logic                       ram_a_rd_en,
  output logic [DRAM_ADDR_WIDTH-1:0] ram_a_read_addr,
  output logic                       ram_b_rd_en,
  output logic [DRAM_ADDR_WIDTH-1:0] ram_b_read_addr,
  output logic                       pe_valid,
  output logic [OPCODE_LEN-1:0]      pe_opcode,
  input  logic                       pe_ready
);

  state_e                     state_q, state_d;
  logic [PC_WIDTH-1:0]        pc_q;
  logic [INST_LEN-1:0]        ir_q;
  logic [DRAM_ADDR_WIDTH-1:0] a_addr_q, b_addr_q;

  logic [OPCODE_LEN-1:0]      ir_opc;
  logic [DRAM_ADDR_WIDTH-1:0] ir_addr;
  inst_class_e                ir_cls;

  logic run_init;  // start accepted: clear PC/IR (and err)
  logic load_ir;   // capture instruction at the end of FETCH
  logic pc_inc;    // advance to the next instruction

`ifdef SIMD_SEQ_ILLEGAL_TRAP_EN
  logic set_err;
  logic err_q;
`endif

  // Outputs depend on state and IR only, never on inst_read_data.
  assign ir_opc  = ir_q[OPC_LSB +: OPCODE_LEN];
  assign ir_addr = ir_q[ADDR_LSB +: DRAM_ADDR_WIDTH];
  assign ir_cls  = decode(OPC_WIDTH'(ir_opc));

  assign busy           = (state_q != S_IDLE);
  assign inst_read_addr = pc_q;
  assign pe_opcode      = pe_valid ? ir_opc : '0;

  // During a strobe the address comes straight from IR; otherwise the last
  // strobed address is replayed so the RAM ports see a stable value.
  assign ram_a_read_addr = ram_a_rd_en ? ir_addr : a_addr_q;
  assign ram_b_read_addr = ram_b_rd_en ? ir_addr : b_addr_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    run_init    = 1'b0;
    load_ir     = 1'b0;
    pc_inc      = 1'b0;
    done        = 1'b0;
    ram_a_rd_en = 1'b0;
    ram_b_rd_en = 1'b0;
    pe_valid    = 1'b0;
`ifdef SIMD_SEQ_ILLEGAL_TRAP_EN
    set_err     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          run_init = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        load_ir = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (ir_cls)
          CLS_NOP: begin
            pc_inc  = 1'b1;
            state_d = S_FETCH;
          end
          CLS_FETCH_A: begin
            ram_a_rd_en = 1'b1;
            pc_inc      = 1'b1;
            state_d     = S_FETCH;
          end
          CLS_FETCH_B: begin
            ram_b_rd_en = 1'b1;
            pc_inc      = 1'b1;
            state_d     = S_FETCH;
          end
          CLS_ALU: begin
            pe_valid = 1'b1;
            if (pe_ready) begin
              pc_inc  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WAIT;
            end
          end
          CLS_STOP: state_d = S_DONE;  // PC stays on the STOP
          default: begin
`ifdef SIMD_SEQ_ILLEGAL_TRAP_EN
            set_err = 1'b1;
            state_d = S_DONE;          // PC stays on the offending opcode
`else
            pc_inc  = 1'b1;
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_WAIT: begin
        pe_valid = 1'b1;
        if (pe_ready) begin
          pc_inc  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: IR and the held RAM addresses are reset as well, so the
      // Moore outputs are defined before the first program runs.
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (run_init) begin
        pc_q <= '0;
        ir_q <= '0;
      end else begin
        if (load_ir) ir_q <= inst_read_data;
        if (pc_inc)  pc_q <= pc_q + PC_WIDTH'(1);  // wraps silently
      end
      if (ram_a_rd_en) a_addr_q <= ir_addr;
      if (ram_b_rd_en) b_addr_q <= ir_addr;
    end
  end

`ifdef SIMD_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (run_init) begin
      err_q <= 1'b0;
    end else if (set_err) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_simd_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_simd_seq_ctrl
//   Scoreboard bench for simd_seq_ctrl. A program-level interpreter predicts,
//   per instruction, which strobes/handshakes appear and in which cycle; the
//   predictions are queued and a negedge monitor pops and compares one entry
//   per cycle in which the DUT presents any strobe, pe_valid or done.
//   A second instance with PC_WIDTH=4 covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_simd_seq_ctrl;

  typedef struct packed {
    logic [3:0]  mask;   // {done, pe_valid, ram_b_rd_en, ram_a_rd_en}
    logic [7:0]  a_addr;
    logic [7:0]  b_addr;
    logic [3:0]  opc;
    logic [11:0] pc;
    int          cyc;
    logic        err;
    logic        busy;
  } ev_t;

  logic        clk      = 1'b0;
  logic        rstn     = 1'b0;
  logic        start    = 1'b0;
  logic        pe_ready = 1'b0;
  logic        busy, done, err;
  logic [11:0] inst_read_addr, inst_read_data;
  logic        ram_a_rd_en, ram_b_rd_en, pe_valid;
  logic [7:0]  ram_a_read_addr, ram_b_read_addr;
  logic [3:0]  pe_opcode;
  logic [11:0] imem [4096];

  always #5 clk = ~clk;

  assign inst_read_data = imem[inst_read_addr];

  simd_seq_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .err(err),
    .inst_read_addr(inst_read_addr), .inst_read_data(inst_read_data),
    .ram_a_rd_en(ram_a_rd_en), .ram_a_read_addr(ram_a_read_addr),
    .ram_b_rd_en(ram_b_rd_en), .ram_b_read_addr(ram_b_read_addr),
    .pe_valid(pe_valid), .pe_opcode(pe_opcode), .pe_ready(pe_ready)
  );

  // Small-PC instance for the wrap-around case
  logic        w4_start = 1'b0;
  logic        w4_ready = 1'b1;
  logic        w4_busy, w4_done, w4_err, w4_a_en, w4_b_en, w4_valid;
  logic [3:0]  w4_addr, w4_opcode;
  logic [11:0] w4_data;
  logic [7:0]  w4_a_addr, w4_b_addr;
  logic [11:0] imem4 [16];

  assign w4_data = imem4[w4_addr];

  simd_seq_ctrl #(.PC_WIDTH(4)) dut_w4 (
    .clk(clk), .rstn(rstn), .start(w4_start), .busy(w4_busy), .done(w4_done), .err(w4_err),
    .inst_read_addr(w4_addr), .inst_read_data(w4_data),
    .ram_a_rd_en(w4_a_en), .ram_a_read_addr(w4_a_addr),
    .ram_b_rd_en(w4_b_en), .ram_b_read_addr(w4_b_addr),
    .pe_valid(w4_valid), .pe_opcode(w4_opcode), .pe_ready(w4_ready)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  ev_t  exp_q [$];
  bit   ready_sched [int];
  logic [7:0] m_last_a = 8'h00;
  logic [7:0] m_last_b = 8'h00;
  logic       m_err    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input string got, input string want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %s, expected %s (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    check(got === want, name, $sformatf("%0h", got), $sformatf("%0h", want));
  endtask

  function automatic string fmt(input ev_t e);
    return $sformatf("mask=%b a=%h b=%h op=%h pc=%h cyc=%0d err=%b busy=%b",
                     e.mask, e.a_addr, e.b_addr, e.opc, e.pc, e.cyc, e.err, e.busy);
  endfunction

  // PE side: the model decides pe_ready for every cycle in which an ALU
  // operation is outstanding; elsewhere pe_ready is random noise.
  initial forever begin
    @(negedge clk);
    pe_ready = ready_sched.exists(cyc) ? ready_sched[cyc] : 1'($urandom_range(0, 1));
  end

  // Monitor: one scoreboard entry per cycle with any visible activity.
  always @(negedge clk) begin : monitor
    ev_t o, e;
    if (rstn) begin
      o.mask = {done, pe_valid, ram_b_rd_en, ram_a_rd_en};
      if (o.mask != 4'b0000) begin
        o.a_addr = ram_a_read_addr;
        o.b_addr = ram_b_read_addr;
        o.opc    = pe_opcode;
        o.pc     = inst_read_addr;
        o.cyc    = cyc;
        o.err    = err;
        o.busy   = busy;
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_event", fmt(o), "no activity");
        end else begin
          e = exp_q.pop_front();
          check(o === e, "event", fmt(o), fmt(e));
        end
      end
    end
  end

  task automatic push(input logic [3:0] mask, input int pc, input int c, input logic [3:0] opc);
    ev_t e;
    e.mask   = mask;
    e.a_addr = m_last_a;
    e.b_addr = m_last_b;
    e.opc    = opc;
    e.pc     = 12'(pc);
    e.cyc    = c;
    e.err    = m_err;
    e.busy   = 1'b1;
    exp_q.push_back(e);
  endtask

  // Instruction-level interpreter. s is the cycle of the first FETCH; each
  // instruction costs one fetch cycle plus one execute cycle plus any stall.
  // stall < 0 picks a random stall (0..3) per ALU instruction.
  task automatic model_run(input int s, input int stall, output int done_cyc);
    int t, pc, op, n, e;
    logic [11:0] inst;
    t = s;
    pc = 0;
    done_cyc = -1;
    m_err = 1'b0;
    for (int guard = 0; guard < 10000; guard++) begin
      inst = imem[pc];
      op   = int'(inst[3:0]);
      e    = t + 1;
      case (op)
        9: begin
          m_last_a = inst[11:4];
          push(4'b0001, pc, e, 4'h0);
          t = e + 1;
        end
        10: begin
          m_last_b = inst[11:4];
          push(4'b0010, pc, e, 4'h0);
          t = e + 1;
        end
        1, 2, 3: begin
          n = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
          for (int i = 0; i <= n; i++) begin
            push(4'b0100, pc, e + i, 4'(op));
            ready_sched[e + i] = (i == n);
          end
          t = e + n + 1;
        end
        8: begin
          push(4'b1000, pc, e + 1, 4'h0);
          done_cyc = e + 1;
          return;
        end
        0: t = e + 1;
        default: begin
`ifdef SIMD_SEQ_ILLEGAL_TRAP_EN
          m_err = 1'b1;
          push(4'b1000, pc, e + 1, 4'h0);
          done_cyc = e + 1;
          return;
`else
          t = e + 1;
`endif
        end
      endcase
      pc = (pc + 1) % 4096;
    end
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;  // the cycle right after the sampling edge: first FETCH
  endtask

  // Run one program to completion. With glitch set, start is pulsed at
  // random while busy and always in the DONE cycle; both must be ignored.
  task automatic run_prog(input int stall, input bit glitch);
    int s, dc;
    pulse_start(s);
    model_run(s, stall, dc);
    if (dc < 0) dc = s + 100;
    forever begin
      @(negedge clk);
      if (cyc > dc) break;
      start = glitch && (cyc == dc || $urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_err", err, m_err);
    chk("idle_a_addr_hold", ram_a_read_addr, m_last_a);
    chk("idle_b_addr_hold", ram_b_read_addr, m_last_b);
    @(negedge clk);
    chk("no_restart_busy", busy, 1'b0);
  endtask

  task automatic load_plan();
    imem[0] = 12'h000;
    imem[1] = 12'h019;
    imem[2] = 12'h01A;
    imem[3] = 12'h001;
    imem[4] = 12'h008;
  endtask

  task automatic load_random(input int len);
    int k, op;
    for (int i = 0; i < len; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0:       op = 0;
        1, 2:    op = 9;
        3, 4:    op = 10;
        5:       op = 1;
        6:       op = 2;
        7:       op = 3;
        8:       op = 0;
        default: begin
          do op = $urandom_range(4, 15); while (op == 8 || op == 9 || op == 10);
        end
      endcase
      imem[i] = {8'($urandom_range(0, 255)), 4'(op)};
    end
    imem[len] = 12'h008;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s, s4, d4, dummy;
    bit seen;
    logic [3:0] pc4;
    logic side;
    for (int i = 0; i < 4096; i++) imem[i] = 12'h008;
    for (int i = 0; i < 16; i++)   imem4[i] = 12'h000;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_pe_valid", pe_valid, 1'b0);
    chk("rst_pe_opcode", pe_opcode, 4'h0);
    chk("rst_a_en", ram_a_rd_en, 1'b0);
    chk("rst_b_en", ram_b_rd_en, 1'b0);
    chk("rst_a_addr", ram_a_read_addr, 8'h00);
    chk("rst_b_addr", ram_b_read_addr, 8'h00);
    chk("rst_pc", inst_read_addr, 12'h000);
    rstn = 1'b1;

    // Reference program, no stall, then with a 3-cycle stall and start glitches
    load_plan();
    run_prog(0, 1'b0);
    run_prog(3, 1'b1);

    // Illegal opcode at PC 2
    load_plan();
    imem[2] = 12'h005;
    run_prog(-1, 1'b1);

    // Random programs
    for (int k = 0; k < 8; k++) begin
      load_random($urandom_range(4, 30));
      run_prog(-1, 1'b1);
    end

    // Reset while waiting on the PE
    imem[0] = 12'h001;
    imem[1] = 12'h008;
    pulse_start(s);
    model_run(s, 10, dummy);
    while (cyc < s + 4) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("wait_rst_pe_valid", pe_valid, 1'b0);
    chk("wait_rst_busy", busy, 1'b0);
    chk("wait_rst_pc", inst_read_addr, 12'h000);
    chk("wait_rst_a_addr", ram_a_read_addr, 8'h00);
    exp_q.delete();
    m_last_a = 8'h00;
    m_last_b = 8'h00;
    m_err    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    load_plan();
    run_prog(0, 1'b0);

    // PC wrap with PC_WIDTH=4: 16 NOPs, then address 0 becomes STOP
    @(negedge clk);
    w4_start = 1'b1;
    @(negedge clk);
    w4_start = 1'b0;
    s4   = cyc;
    seen = 1'b0;
    d4   = -1;
    pc4  = 4'h0;
    side = 1'b0;
    while (!seen && cyc < s4 + 60) begin
      @(negedge clk);
      if (cyc == s4 + 2) imem4[0] = 12'h008;
      side = side | w4_a_en | w4_b_en | w4_valid | w4_err | (w4_opcode != 4'h0)
                  | (w4_a_addr != 8'h00) | (w4_b_addr != 8'h00) | !w4_busy;
      if (w4_done) begin
        seen = 1'b1;
        d4   = cyc - s4;
        pc4  = w4_addr;
      end
    end
    chk("wrap_done_seen", seen, 1'b1);
    chk("wrap_done_cycle", d4, 34);
    chk("wrap_stop_pc", pc4, 4'h0);
    chk("wrap_side_outputs", side, 1'b0);
    @(negedge clk);
    chk("wrap_idle", w4_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simd_seq_ctrl.md
# simd_seq_ctrl

Program sequencer for the SIMD processing element. Walks the instruction memory from address 0, decodes each 12-bit instruction, and drives the RAM A/B read ports and the PE operation handshake. It sits between the instruction memory, the two vector data RAMs and `pe_fetch`/execute, and runs one program per `start` pulse until a STOP instruction.

## Interface
- `OPCODE_LEN`, 4: opcode field width, `inst[OPCODE_LEN-1:0]`.
- `PC_WIDTH`, 12: program counter width.
- `INST_LEN`, 12: instruction width.
- `DRAM_DEPTH`, 256: data RAM depth.
  - Localparam `DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH)`.
  - The address field is `inst[OPCODE_LEN +: DRAM_ADDR_WIDTH]`.
- `clk`  in  1  sole clock, rising edge.
- `rstn`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  one-cycle request to run the program from PC 0. Ignored unless IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after STOP is decoded.
- `err`  out  1  illegal-opcode trap, sticky until next `start` (only with the macro).
- `inst_read_addr`  out  PC_WIDTH  instruction address (= PC).
- `inst_read_data`  in  INST_LEN  instruction. Combinational read, valid in the same cycle.
- `ram_a_rd_en`  out  1  RAM A read strobe.
- `ram_a_read_addr`  out  DRAM_ADDR_WIDTH  RAM A address.
- `ram_b_rd_en`  out  1  RAM B read strobe.
- `ram_b_read_addr`  out  DRAM_ADDR_WIDTH  RAM B address.
- `pe_valid`  out  1  PE operation request.
- `pe_opcode`  out  OPCODE_LEN  operation presented with `pe_valid`.
- `pe_ready`  in  1  PE accepts the operation.

## Operation
- Opcodes:
  - NOP = 0x0
  - ADD = 0x1, SUB = 0x2, MUL = 0x3 (ALU group)
  - STOP = 0x8
  - FETCH_A = 0x9, FETCH_B = 0xA
  - All other values are illegal.
- States: IDLE, FETCH, EXEC, WAIT, DONE.
- IDLE
  - `start` → FETCH, with PC ← 0, IR ← 0 and `err` ← 0.
- FETCH
  - `inst_read_addr` = PC.
  - IR ← `inst_read_data` at the clock edge; → EXEC.
- EXEC: decodes IR.
  - NOP: PC+1 → FETCH.
  - FETCH_A: `ram_a_rd_en` = 1 and `ram_a_read_addr` = IR address field for this one cycle; PC+1 → FETCH.
  - FETCH_B: same as FETCH_A, on the RAM B port.
  - ALU group: `pe_valid` = 1, `pe_opcode` = IR opcode.
    - If `pe_ready` = 1: PC+1 → FETCH.
    - Otherwise → WAIT.
  - STOP: → DONE; PC is not incremented.
  - Illegal opcode: depends on the macro (see Configuration).
- WAIT
  - `pe_valid` = 1 and `pe_opcode` stay stable until `pe_ready`.
  - On `pe_ready`: PC+1 → FETCH.
- DONE
  - `done` = 1 for one cycle; → IDLE.
- Outputs are decoded from the state and IR only (Moore), never from `inst_read_data`.
- Read addresses hold their last value when strobes are low.
- `pe_opcode` is 0 when `pe_valid` is low.
- PC is PC_WIDTH bits and increments modulo 2^PC_WIDTH: from all-ones it wraps to 0 with no flag.
- `start` is ignored while `busy` = 1, including in DONE.
- Reset: async `rstn` low forces IDLE from any state.
  - PC = 0, IR = 0, `err` = 0.
  - All strobes, `busy`, `done` and `pe_valid` = 0.
  - All addresses = 0.
  - Any in-flight handshake is abandoned.

## Timing
- Two cycles per NOP, FETCH_A and FETCH_B instruction.
- ALU instruction: 2 cycles + N, where N is the number of cycles `pe_ready` stays low.
- STOP: the EXEC cycle of STOP is followed by exactly one DONE cycle (`done` high); IDLE follows.
- `start` sampled high at edge k gives FETCH (PC 0) in cycle k+1.
- RAM strobes are single-cycle pulses. RAM read data is consumed downstream; it is not captured here.

## Configuration
- `SIMD_SEQ_ILLEGAL_TRAP_EN` defined: an illegal opcode in EXEC sets `err` = 1 and goes to DONE (`done` pulses). PC stays at the offending instruction.
- Macro undefined: illegal opcodes execute as NOP (PC+1 → FETCH). `err` is tied to 0.

## Structure
- Package `simd_pkg` holds:
  - the opcode enum (`OPCODE_LEN` wide);
  - the state enum;
  - the field-extraction localparams: opcode LSB/width, address LSB.
- Single module; no sub-module. Decode is a function in `simd_pkg`.

## Test plan
- Program `0:0x000, 1:0x019, 2:0x01A, 3:0x001, 4:0x008`, `pe_ready` = 1, `start` at edge 0:
  - `ram_a_rd_en` with addr 1 in cycle 4;
  - `ram_b_rd_en` with addr 1 in cycle 6;
  - `pe_valid` with opcode 1 in cycle 8;
  - `done` in cycle 11;
  - `busy` low in cycle 12.
- Same program with `pe_ready` held low 3 cycles after `pe_valid` rises: `pe_valid`/opcode 1 held 4 cycles and `done` shifts by 3.
- `start` pulsed while busy: no restart, PC sequence unchanged. `start` in DONE is ignored.
- `rstn` dropped during WAIT: immediately `pe_valid` = 0, `busy` = 0, PC = 0. Next `start` reruns from 0.
- Opcode 0x5 at PC 2:
  - with the macro: `err` = 1, `done` pulses and PC stays at 2;
  - without the macro: treated as NOP.
- PC_WIDTH = 4, NOPs at 0..15, STOP at 0 reached after wrap: the second pass hits STOP at PC 0 and `done` asserts.
